eth_rx_parser: RTL and testbench
================================

ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter MAC_ADDR_FPGA, 48'hfa163e55ca02, station address accepted as destination.
REQ-002 Parameter ETHERTYPE, 16'h88b5, required ethertype; packets with any other value are dropped.
REQ-003 Parameter ACCEPT_BCAST, 1'b1, when 1 destination ff:ff:ff:ff:ff:ff is also accepted.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stream_in_DATA/KEEP/LAST/VALID  in  64/8/1/1  AXI-Stream ingress from MAC, byte 0 in DATA[7:0].
REQ-007 stream_in_READY  out  1  ingress backpressure.
REQ-008 stream_out_DATA/KEEP/LAST/VALID  out  64/8/1/1  payload egress.
REQ-009 stream_out_READY  in  1  egress backpressure.
REQ-010 stream_out_DEST  out  8  destination id from header, stable for the whole packet.
REQ-011 stream_out_SRC_MAC  out  48  source MAC from header, stable for the whole packet.
REQ-012 pkt_ok_cnt, pkt_drop_cnt, pkt_runt_cnt  out  32 each  statistics counters.

Function
REQ-013 Header is exactly two flits: bytes 0-5 dst MAC, 6-11 src MAC, 12-13 ethertype, 14 dest id, 15 reserved; payload starts at flit 2, lane-aligned, forwarded unshifted.
REQ-014 MAC byte 0 is the address MSB; ethertype byte 12 is the MSB.
REQ-015 FSM states HDR0, HDR1, PAYLOAD, DROP; reset state HDR0.
REQ-016 HDR0: on ingress handshake latch dst MAC and src MAC[47:32] -> HDR1; if LAST set: pkt_runt_cnt+1, stay HDR0.
REQ-017 HDR1: on handshake evaluate filter (dst match or bcast-accept) AND ethertype match; pass with LAST clear -> PAYLOAD; fail with LAST clear -> DROP; any with LAST set -> pkt_runt_cnt+1, HDR0.
REQ-018 In HDR0, HDR1 and DROP stream_in_READY=1 irrespective of stream_out_READY; header flits never appear on egress.
REQ-019 PAYLOAD: each accepted flit forwarded with DATA/KEEP/LAST unchanged; on LAST handshake pkt_ok_cnt+1 -> HDR0.
REQ-020 DROP: consume flits; on LAST handshake pkt_drop_cnt+1 -> HDR0.
REQ-021 Egress registered through a 2-entry skid buffer: latency ingress->egress exactly 1 cycle when egress ready; full throughput (1 flit/cycle) under continuous ready; no flit lost or duplicated when stream_out_READY deasserts mid-packet.
REQ-022 In PAYLOAD stream_in_READY = skid buffer not full (registered, no combinational path from stream_out_READY).
REQ-023 stream_out_DEST and stream_out_SRC_MAC update only on HDR1->PAYLOAD transition, not while a previous packet's flits remain in the skid buffer.
REQ-024 Counters saturate at 32'hffffffff; at most one counter increments per cycle.
REQ-025 stream_out_VALID never asserts with KEEP==0; KEEP is passed as received.

Reset
REQ-026 rst on clk edge: FSM->HDR0, skid buffer emptied, stream_out_VALID=0, stream_out_DATA/KEEP/LAST=0, DEST=0, SRC_MAC=0, all counters 0, stream_in_READY=0 during reset then 1 the cycle after.
REQ-027 rst mid-packet: partial packet abandoned, no counter increments; the following ingress flit is treated as HDR0.

Structure
REQ-028 Shared package eth_pkg holds header byte offsets, HDR_FLITS=2, default MAC/ethertype constants and the fsm state enum.
REQ-029 Skid buffer is sub-module axis_skid_buf (data width 64+8+1), reusable elsewhere.

Verification
REQ-030 dst fa163e55ca02, type 88b5, dest 8'h03, 3 payload flits, ready=1 -> 3 egress flits 1 cycle later, DEST=03, pkt_ok_cnt=1.
REQ-031 dst 0cc47a88c047 (mismatch), 4 payload flits -> no egress VALID, ingress READY held 1, pkt_drop_cnt=1.
REQ-032 Single flit with LAST, then 2-flit header with LAST on flit 1 -> pkt_runt_cnt=2, no egress, next good packet passes.
REQ-033 Good 8-payload packet, stream_out_READY toggled 1010... -> 8 flits in order, unchanged data, last flit KEEP 8'h0f intact.
REQ-034 Back-to-back good packets dest 01 then 02, egress stalled 5 cycles at packet boundary -> packet 1 flits carry DEST=01, packet 2 DEST=02.
REQ-035 rst asserted at payload flit 2 of a good packet -> all outputs/counters zero, following good packet counted pkt_ok_cnt=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive path.
package eth_pkg;

  localparam int unsigned FLIT_BYTES = 8;
  localparam int unsigned HDR_FLITS  = 2;

  // Byte offsets within the 16-byte header
  localparam int unsigned OFF_DST_MAC   = 0;
  localparam int unsigned OFF_SRC_MAC   = 6;
  localparam int unsigned OFF_ETHERTYPE = 12;
  localparam int unsigned OFF_DEST_ID   = 14;
  localparam int unsigned OFF_RSVD      = 15;

  localparam logic [47:0] DEF_MAC_ADDR  = 48'hfa163e55ca02;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88b5;
  localparam logic [47:0] BCAST_MAC     = '1;

  typedef enum logic [1:0] {
    ST_HDR0    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } fsm_state_e;

  // Byte of the current flit that corresponds to header offset hdr_off
  function automatic logic [7:0] flit_byte(input logic [63:0] data, input int unsigned hdr_off);
    return data[8*(hdr_off % FLIT_BYTES) +: 8];
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer; ready depends only on internal occupancy.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

  // Next-state of the two entries; head is always the egress register
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    push   = in_valid && in_ready;
    pop    = out_valid && out_ready;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/eth_rx_parser.sv
// Strips a two-flit header, filters on address/ethertype, forwards payload.
module eth_rx_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_FPGA = DEF_MAC_ADDR,
  parameter logic [15:0] ETHERTYPE     = DEF_ETHERTYPE,
  parameter logic        ACCEPT_BCAST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [63:0] stream_out_DATA,
  output logic [7:0]  stream_out_KEEP,
  output logic        stream_out_LAST,
  output logic        stream_out_VALID,
  input  logic        stream_out_READY,
  output logic [7:0]  stream_out_DEST,
  output logic [47:0] stream_out_SRC_MAC,
  output logic [31:0] pkt_ok_cnt,
  output logic [31:0] pkt_drop_cnt,
  output logic [31:0] pkt_runt_cnt
);

  fsm_state_e  state_q, state_d;
  logic        rdy_en_q;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [15:0] src_hi_q, src_hi_d;
  logic [7:0]  dest_q, dest_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_dest_q, pend_dest_d;
  logic [47:0] pend_src_q, pend_src_d;
  logic [31:0] ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d, runt_cnt_q, runt_cnt_d;

  logic        in_ready, in_hs, ok_inc, drop_inc, runt_inc, addr_ok, pass;
  logic [47:0] hdr_dst;
  logic [15:0] hdr_src_hi, hdr_type;
  logic [31:0] hdr_src_lo;
  logic [7:0]  hdr_dest;
  logic        skid_push, skid_in_ready, skid_out_valid;
  logic [72:0] skid_out_data;

  // Header field extraction, filter, FSM next state and counters
  always_comb begin
    state_d     = state_q;
    dst_mac_d   = dst_mac_q;
    src_hi_d    = src_hi_q;
    dest_d      = dest_q;
    src_mac_d   = src_mac_q;
    pend_d      = pend_q;
    pend_dest_d = pend_dest_q;
    pend_src_d  = pend_src_q;
    ok_inc      = 1'b0;
    drop_inc    = 1'b0;
    runt_inc    = 1'b0;
    skid_push   = 1'b0;
    hdr_dst     = '0;
    hdr_src_hi  = '0;
    hdr_src_lo  = '0;
    hdr_type    = '0;

    for (int unsigned i = 0; i < 6; i++)
      hdr_dst[47-8*i -: 8] = flit_byte(stream_in_DATA, OFF_DST_MAC + i);
    for (int unsigned i = 0; i < 2; i++)
      hdr_src_hi[15-8*i -: 8] = flit_byte(stream_in_DATA, OFF_SRC_MAC + i);
    for (int unsigned i = 0; i < 4; i++)
      hdr_src_lo[31-8*i -: 8] = flit_byte(stream_in_DATA, OFF_SRC_MAC + 2 + i);
    for (int unsigned i = 0; i < 2; i++)
      hdr_type[15-8*i -: 8] = flit_byte(stream_in_DATA, OFF_ETHERTYPE + i);
    hdr_dest = flit_byte(stream_in_DATA, OFF_DEST_ID);

    addr_ok = (dst_mac_q == MAC_ADDR_FPGA) || (ACCEPT_BCAST && (dst_mac_q == BCAST_MAC));
    pass    = addr_ok && (hdr_type == ETHERTYPE);

    // Payload is held off while a new header waits for the old packet to drain
    in_ready = rdy_en_q && ((state_q != ST_PAYLOAD) || (skid_in_ready && !pend_q));
    in_hs    = stream_in_VALID && in_ready;

    if (pend_q && !skid_out_valid) begin
      dest_d    = pend_dest_q;
      src_mac_d = pend_src_q;
      pend_d    = 1'b0;
    end

    unique case (state_q)
      ST_HDR0: if (in_hs) begin
        if (stream_in_LAST) begin
          runt_inc = 1'b1;
        end else begin
          dst_mac_d = hdr_dst;
          src_hi_d  = hdr_src_hi;
          state_d   = ST_HDR1;
        end
      end
      ST_HDR1: if (in_hs) begin
        if (stream_in_LAST) begin
          runt_inc = 1'b1;
          state_d  = ST_HDR0;
        end else if (pass) begin
          state_d = ST_PAYLOAD;
          if (!skid_out_valid) begin
            dest_d    = hdr_dest;
            src_mac_d = {src_hi_q, hdr_src_lo};
          end else begin
            pend_d      = 1'b1;
            pend_dest_d = hdr_dest;
            pend_src_d  = {src_hi_q, hdr_src_lo};
          end
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_PAYLOAD: if (in_hs) begin
        skid_push = (stream_in_KEEP != '0);
        if (stream_in_LAST) begin
          ok_inc  = 1'b1;
          state_d = ST_HDR0;
        end
      end
      ST_DROP: if (in_hs && stream_in_LAST) begin
        drop_inc = 1'b1;
        state_d  = ST_HDR0;
      end
      default: state_d = ST_HDR0;
    endcase

    ok_cnt_d   = ok_cnt_q   + {31'd0, ok_inc   && (ok_cnt_q   != '1)};
    drop_cnt_d = drop_cnt_q + {31'd0, drop_inc && (drop_cnt_q != '1)};
    runt_cnt_d = runt_cnt_q + {31'd0, runt_inc && (runt_cnt_q != '1)};
  end

  // State, header and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR0;
      rdy_en_q    <= 1'b0;
      dst_mac_q   <= '0;
      src_hi_q    <= '0;
      dest_q      <= '0;
      src_mac_q   <= '0;
      pend_q      <= 1'b0;
      pend_dest_q <= '0;
      pend_src_q  <= '0;
      ok_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      runt_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      dst_mac_q   <= dst_mac_d;
      src_hi_q    <= src_hi_d;
      dest_q      <= dest_d;
      src_mac_q   <= src_mac_d;
      pend_q      <= pend_d;
      pend_dest_q <= pend_dest_d;
      pend_src_q  <= pend_src_d;
      ok_cnt_q    <= ok_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      runt_cnt_q  <= runt_cnt_d;
    end
  end

  axis_skid_buf #(.WIDTH(73)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({stream_in_LAST, stream_in_KEEP, stream_in_DATA}),
    .in_valid  (skid_push),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out_data),
    .out_valid (skid_out_valid),
    .out_ready (stream_out_READY)
  );

  assign stream_in_READY    = in_ready;
  assign stream_out_DATA    = skid_out_data[63:0];
  assign stream_out_KEEP    = skid_out_data[71:64];
  assign stream_out_LAST    = skid_out_data[72];
  assign stream_out_VALID   = skid_out_valid;
  assign stream_out_DEST    = dest_q;
  assign stream_out_SRC_MAC = src_mac_q;
  assign pkt_ok_cnt         = ok_cnt_q;
  assign pkt_drop_cnt       = drop_cnt_q;
  assign pkt_runt_cnt       = runt_cnt_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Randomized self-checking bench for eth_rx_parser with a packet-level model.
module tb_eth_rx_parser;

  localparam logic [47:0] MY_MAC = 48'hfa163e55ca02;
  localparam logic [47:0] BC_MAC = 48'hffffffffffff;
  localparam logic [15:0] MY_TYPE = 16'h88b5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep, out_dest;
  logic        out_last, out_valid, out_ready = 1'b1;
  logic [47:0] out_src;
  logic [31:0] ok_cnt, drop_cnt, runt_cnt;

  eth_rx_parser dut (
    .clk(clk), .rst(rst),
    .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
    .stream_in_VALID(in_valid), .stream_in_READY(in_ready),
    .stream_out_DATA(out_data), .stream_out_KEEP(out_keep), .stream_out_LAST(out_last),
    .stream_out_VALID(out_valid), .stream_out_READY(out_ready),
    .stream_out_DEST(out_dest), .stream_out_SRC_MAC(out_src),
    .pkt_ok_cnt(ok_cnt), .pkt_drop_cnt(drop_cnt), .pkt_runt_cnt(runt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; bit fwd; } flit_t;
  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; logic [7:0] dest; logic [47:0] src; } exp_t;

  flit_t pkt[$];
  exp_t  exp_q[$];
  int    lat_q[$];
  int    n_checks = 0, n_errors = 0;
  int    cyc = 0;
  int    m_ok = 0, m_drop = 0, m_runt = 0;
  int    rdy_mode = 0;
  bit    lat_en = 1'b0, gap_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Egress ready pattern generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom % 2);
      2: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Egress monitor against the expected-flit queue
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      check_eq("keep_nonzero", 64'(out_keep != 8'h00), 1);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_egress", 64'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e.data);
          check_eq("out_keep_last", {55'd0, out_last, out_keep}, {55'd0, e.last, e.keep});
          check_eq("out_dest", 64'(out_dest), 64'(e.dest));
          check_eq("out_src_mac", 64'(out_src), 64'(e.src));
          if (lat_en) begin
            check_eq("latency_rec", 64'(lat_q.size() != 0), 1);
            if (lat_q.size() != 0) check_eq("latency", 64'(cyc - lat_q.pop_front()), 1);
          end
        end
      end
    end
  end

  // Builds a packet from header fields; npay<=0 makes a runt of (2+npay) flits.
  // The reference model classifies it and queues the flits that must appear.
  task automatic build_pkt(input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] dest,
                           input logic [47:0] src, input int npay, input logic [7:0] last_keep,
                           input bit rand_keep);
    logic [7:0] hb[16];
    flit_t f;
    bit good;
    int nfl;
    pkt.delete();
    for (int i = 0; i < 6; i++) hb[i] = dst[47-8*i -: 8];
    for (int i = 0; i < 6; i++) hb[6+i] = src[47-8*i -: 8];
    hb[12] = etype[15:8];
    hb[13] = etype[7:0];
    hb[14] = dest;
    hb[15] = 8'($urandom);
    nfl = (npay <= 0) ? 2 + npay : 2 + npay;
    good = (npay > 0) && ((dst == MY_MAC) || (dst == BC_MAC)) && (etype == MY_TYPE);
    for (int k = 0; k < nfl; k++) begin
      f.last = (k == nfl - 1);
      if (k < 2) begin
        for (int j = 0; j < 8; j++) f.data[8*j +: 8] = hb[8*k+j];
        f.keep = 8'hff;
        f.fwd  = 1'b0;
      end else begin
        f.data = {$urandom, $urandom};
        f.keep = f.last ? last_keep : (rand_keep ? 8'($urandom) : 8'hff);
        f.fwd  = good && (f.keep != 8'h00);
        if (f.fwd) exp_q.push_back('{f.data, f.keep, f.last, dest, src});
      end
      pkt.push_back(f);
    end
    if (npay <= 0) m_runt++;
    else if (good) m_ok++;
    else m_drop++;
  endtask

  // Drives the first nmax flits of pkt; all_rdy demands ready on every flit
  task automatic send_pkt(input int nmax, input bit all_rdy);
    bit got;
    for (int i = 0; i < pkt.size() && i < nmax; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data = pkt[i].data; in_keep = pkt[i].keep; in_last = pkt[i].last; in_valid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 300 && !got; w++) begin
        @(negedge clk);
        if (w == 0 && (i < 2 || all_rdy)) check_eq("in_ready_hdr", 64'(in_ready), 1);
        got = in_ready;
        if (got && lat_en && pkt[i].fwd) lat_q.push_back(cyc);
        @(posedge clk); #1;
      end
      if (!got) check_eq("in_ready_timeout", 64'(in_ready), 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    rdy_mode = 0;
    for (int w = 0; w < 600 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_drain"}, 64'(exp_q.size()), 0);
    check_eq({tag, "_ok_cnt"}, 64'(ok_cnt), 64'(m_ok));
    check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    check_eq({tag, "_runt_cnt"}, 64'(runt_cnt), 64'(m_runt));
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 0);
    check_eq({tag, "_data"}, out_data, 0);
    check_eq({tag, "_keep_last"}, {55'd0, out_last, out_keep}, 0);
    check_eq({tag, "_dest"}, 64'(out_dest), 0);
    check_eq({tag, "_src"}, 64'(out_src), 0);
    check_eq({tag, "_ok"}, 64'(ok_cnt), 0);
    check_eq({tag, "_drop"}, 64'(drop_cnt), 0);
    check_eq({tag, "_runt"}, 64'(runt_cnt), 0);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int kind, np;
    logic [47:0] dst;
    logic [15:0] ety;
    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("ready_after_reset", 64'(in_ready), 1);
    @(posedge clk); #1;

    // Good packet, 1-cycle latency
    lat_en = 1'b1;
    build_pkt(MY_MAC, MY_TYPE, 8'h03, 48'h0a0b0c0d0e0f, 3, 8'hff, 1'b0);
    send_pkt(99, 1'b0);
    drain_and_check("good3");
    lat_en = 1'b0;
    lat_q.delete();

    // Address mismatch with egress stalled: dropped, ingress never stalls
    rdy_mode = 3;
    build_pkt(48'h0cc47a88c047, MY_TYPE, 8'h07, 48'h112233445566, 4, 8'hff, 1'b0);
    send_pkt(99, 1'b1);
    drain_and_check("drop_dst");

    // Runts then a good packet
    build_pkt(MY_MAC, MY_TYPE, 8'h01, 48'h1, -1, 8'hff, 1'b0);
    send_pkt(99, 1'b1);
    build_pkt(MY_MAC, MY_TYPE, 8'h01, 48'h2, 0, 8'hff, 1'b0);
    send_pkt(99, 1'b1);
    build_pkt(MY_MAC, MY_TYPE, 8'h09, 48'h3, 2, 8'hff, 1'b0);
    send_pkt(99, 1'b0);
    drain_and_check("runts");

    // Toggling egress ready, partial last flit
    rdy_mode = 2;
    build_pkt(MY_MAC, MY_TYPE, 8'h04, 48'hdeadbeef0001, 8, 8'h0f, 1'b0);
    send_pkt(99, 1'b0);
    drain_and_check("toggle8");

    // Back-to-back packets with egress stalled across the boundary
    rdy_mode = 3;
    build_pkt(MY_MAC, MY_TYPE, 8'h01, 48'h010101010101, 2, 8'hff, 1'b0);
    build_pkt(BC_MAC, MY_TYPE, 8'h02, 48'h020202020202, 3, 8'hff, 1'b0);
    fork
      begin
        build_pkt(MY_MAC, MY_TYPE, 8'h01, 48'h010101010101, 0, 8'hff, 1'b0);
      end
    join
    // rebuild cleanly: discard the speculative builds above and redo in send order
    exp_q.delete();
    m_ok = m_ok - 2;
    m_runt = m_runt - 1;
    fork
      begin
        build_pkt(MY_MAC, MY_TYPE, 8'h01, 48'h010101010101, 2, 8'hff, 1'b0);
        send_pkt(99, 1'b0);
        build_pkt(BC_MAC, MY_TYPE, 8'h02, 48'h020202020202, 3, 8'hff, 1'b0);
        send_pkt(99, 1'b0);
      end
      begin
        repeat (9) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain_and_check("b2b");

    // Reset in the middle of a good packet
    build_pkt(MY_MAC, MY_TYPE, 8'h05, 48'h555555555555, 5, 8'hff, 1'b0);
    send_pkt(4, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero_outputs("midrst");
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    m_ok = 0; m_drop = 0; m_runt = 0;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_ready_after", 64'(in_ready), 1);
    @(posedge clk); #1;
    build_pkt(MY_MAC, MY_TYPE, 8'h06, 48'h666666666666, 3, 8'hff, 1'b0);
    send_pkt(99, 1'b0);
    drain_and_check("after_rst");

    // Randomized traffic
    for (int p = 0; p < 60; p++) begin
      rdy_mode = $urandom_range(0, 2);
      gap_en   = 1'($urandom % 2);
      kind     = $urandom_range(0, 5);
      np       = $urandom_range(1, 6);
      dst      = MY_MAC;
      ety      = MY_TYPE;
      case (kind)
        2: dst = BC_MAC;
        3: dst = {$urandom, 16'($urandom)};
        4: ety = 16'($urandom) | 16'h0001;
        5: np  = -$urandom_range(0, 1);
        default: ;
      endcase
      if (ety == MY_TYPE && kind == 4) ety = 16'h0800;
      build_pkt(dst, ety, 8'($urandom), {$urandom, 16'($urandom)}, np, 8'($urandom_range(1, 255)), 1'b1);
      send_pkt(99, 1'b0);
    end
    gap_en = 1'b0;
    drain_and_check("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
